// File: rtl/video_noise_pkg.sv
// video_noise_pkg: shared constants, mode type and LFSR helpers for video_noise_gen.
//   LFSR_TAPS : Galois feedback taps (shift right, XOR taps when LSB is 1)
//   SEED_STEP : per-channel seed offset
//   vmode_t   : frame-latched mode {pal, sd}
//   lfsr_next : one LFSR step
//   lfsr_seed : seed for channel idx
package video_noise_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SEED_STEP = 16'h1357;

    typedef struct packed {
        logic pal;
        logic sd;
    } vmode_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // An all-zero state would lock the LFSR up, so it is replaced with 1.
    function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int idx);
        logic [15:0] s;
        s = base ^ (16'(idx) * SEED_STEP);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/video_noise_gen_lfsr.sv
// video_noise_lfsr: one 16-bit Galois noise LFSR with a line snapshot for replay.
//   clk, reset_n : clock, asynchronous active-low reset (loads seed)
//   seed         : reset value of state and snapshot
//   step         : advance one LFSR step
//   save         : copy current state into the snapshot
//   restore      : reload state from the snapshot (wins over step)
//   state        : current LFSR state
module video_noise_lfsr
    import video_noise_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    input  logic        step,
    input  logic        save,
    input  logic        restore,
    output logic [15:0] state
);

    logic [15:0] snap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= seed;
            snap  <= seed;
        end else begin
            if (save) snap <= state;
            if (restore) state <= snap;
            else if (step) state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/video_noise_gen.sv
// video_noise_gen: 15/31 kHz NTSC/PAL raster timing with CHANNELS LFSR noise channels.
//   clk, reset_n    : clock, asynchronous active-low reset
//   pal, scandouble : video mode, latched at the frame boundary
//   freeze          : hold all LFSRs
//   chan_en         : per-channel enable (disabled channel outputs 0)
//   pattern         : colour-bar select, only when VNG_PATTERN_EN is defined
//   ce_pix          : pixel clock enable, one clk wide
//   hcount, vcount  : registered raster position
//   HBlank, HSync, VBlank, VSync : registered timing, active high
//   video           : CHANNELS x COLOR_W pixels, channel 0 in the LSBs
// Optional feature macro: VNG_PATTERN_EN (8 vertical colour bars).
module video_noise_gen
    import video_noise_pkg::*;
#(
    parameter int          COLOR_W  = 8,
    parameter int          CHANNELS = 3,
    parameter int          CE_DIV   = 8,
    parameter int          H_ACTIVE = 320,
    parameter int          H_FP     = 8,
    parameter int          H_SYNC   = 32,
    parameter int          H_BP     = 40,
    parameter int          V_ACT_N  = 240,
    parameter int          V_BP_N   = 16,
    parameter int          V_ACT_P  = 288,
    parameter int          V_BP_P   = 18,
    parameter int          V_FP     = 3,
    parameter int          V_SYNC   = 3,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         pal,
    input  logic                         scandouble,
    input  logic                         freeze,
    input  logic [CHANNELS-1:0]          chan_en,
`ifdef VNG_PATTERN_EN
    input  logic                         pattern,
`endif
    output logic                         ce_pix,
    output logic [8:0]                   hcount,
    output logic [9:0]                   vcount,
    output logic                         HBlank,
    output logic                         HSync,
    output logic                         VBlank,
    output logic                         VSync,
    output logic [CHANNELS*COLOR_W-1:0]  video
);

    localparam int DW  = $clog2(CE_DIV);
    localparam int VTN = V_ACT_N + V_FP + V_SYNC + V_BP_N;
    localparam int VTP = V_ACT_P + V_FP + V_SYNC + V_BP_P;

    localparam logic [DW-1:0] DIV_LAST   = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST_D = DW'(CE_DIV / 2 - 1);
    localparam logic [8:0]    H_LAST     = 9'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [8:0]    H_ACT      = 9'(H_ACTIVE);
    localparam logic [8:0]    HS_BEG     = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0]    HS_END     = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VN_LAST    = 10'(VTN - 1);
    localparam logic [9:0]    VN_LAST_D  = 10'(2 * VTN - 1);
    localparam logic [9:0]    VP_LAST    = 10'(VTP - 1);
    localparam logic [9:0]    VP_LAST_D  = 10'(2 * VTP - 1);
    localparam logic [9:0]    VS_BEG     = 10'(V_FP);
    localparam logic [9:0]    VS_END     = 10'(V_FP + V_SYNC);

    vmode_t                        mode;
    logic [DW-1:0]                 div;
    logic [8:0]                    h;
    logic [9:0]                    v;
    logic [9:0]                    v_last;
    logic [9:0]                    v_act;
    logic [9:0]                    line;
    logic                          h_wrap;
    logic                          v_wrap;
    logic                          h_blank;
    logic                          v_blank;
    logic                          step;
    logic                          save;
    logic                          restore;
    logic [CHANNELS*16-1:0]        states;
    logic [CHANNELS*COLOR_W-1:0]   pix;
    logic                          unused_state;

    assign ce_pix  = div == (mode.sd ? DIV_LAST_D : DIV_LAST);
    assign v_last  = mode.pal ? (mode.sd ? VP_LAST_D : VP_LAST) : (mode.sd ? VN_LAST_D : VN_LAST);
    assign v_act   = mode.pal ? 10'(V_ACT_P) : 10'(V_ACT_N);
    assign line    = mode.sd ? (v >> 1) : v;
    assign h_wrap  = h == H_LAST;
    assign v_wrap  = v == v_last;
    assign h_blank = h >= H_ACT;
    assign v_blank = line >= v_act;
    assign step    = ce_pix & ~h_blank & ~v_blank & ~freeze;
    // Scandoubled lines are shown twice: the even line snapshots the LFSRs at
    // its start and restores them at its end, so the odd line regenerates it.
    assign save    = ce_pix & mode.sd & ~v[0] & (h == 9'd0);
    assign restore = ce_pix & mode.sd & ~v[0] & h_wrap;
    assign unused_state = ^states;

`ifdef VNG_PATTERN_EN
    logic [2:0] bar;
    assign bar = 3'(h / 9'(H_ACTIVE / 8));
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [COLOR_W-1:0] src;
        video_noise_lfsr u_lfsr (
            .clk     (clk),
            .reset_n (reset_n),
            .seed    (lfsr_seed(SEED, i)),
            .step    (step),
            .save    (save),
            .restore (restore),
            .state   (states[i*16 +: 16])
        );
`ifdef VNG_PATTERN_EN
        assign src = pattern ? {COLOR_W{bar[i % 3]}} : states[i*16 + 15 -: COLOR_W];
`else
        assign src = states[i*16 + 15 -: COLOR_W];
`endif
        assign pix[i*COLOR_W +: COLOR_W] = (chan_en[i] & ~h_blank & ~v_blank) ? src : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            h      <= '0;
            v      <= '0;
            mode   <= '0;
            hcount <= '0;
            vcount <= '0;
            HBlank <= 1'b0;
            HSync  <= 1'b0;
            VBlank <= 1'b0;
            VSync  <= 1'b0;
            video  <= '0;
        end else begin
            div <= ce_pix ? '0 : div + 1'b1;
            if (ce_pix) begin
                h <= h_wrap ? 9'd0 : h + 9'd1;
                if (h_wrap) begin
                    v <= v_wrap ? 10'd0 : v + 10'd1;
                    if (v_wrap) mode <= vmode_t'({pal, scandouble});
                end
                hcount <= h;
                vcount <= v;
                HBlank <= h_blank;
                HSync  <= h >= HS_BEG && h < HS_END;
                VBlank <= v_blank;
                VSync  <= line >= v_act + VS_BEG && line < v_act + VS_END;
                video  <= pix;
            end
        end
    end

endmodule

// File: tb/tb_video_noise_gen.sv
// tb_video_noise_gen: self-checking bench for video_noise_gen on a reduced raster
// (24x13 NTSC, 24x16 PAL, CE_DIV=4) checked pixel by pixel against a reference model.
module tb_video_noise_gen;

    localparam int CW  = 8;
    localparam int CH  = 3;
    localparam int CE  = 4;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HS  = 4;
    localparam int HBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VAN = 8;
    localparam int VBN = 2;
    localparam int VAP = 10;
    localparam int VBP = 3;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VTN = VAN + VFP + VS + VBN;
    localparam int VTP = VAP + VFP + VS + VBP;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 pal = 1'b0;
    logic                 scandouble = 1'b0;
    logic                 freeze = 1'b0;
    logic [CH-1:0]        chan_en = '1;
    logic                 ce_pix;
    logic [8:0]           hcount;
    logic [9:0]           vcount;
    logic                 HBlank, HSync, VBlank, VSync;
    logic [CH*CW-1:0]     video;

    int errors = 0;
    int checks = 0;

    video_noise_gen #(
        .COLOR_W(CW), .CHANNELS(CH), .CE_DIV(CE),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACT_N(VAN), .V_BP_N(VBN), .V_ACT_P(VAP), .V_BP_P(VBP),
        .V_FP(VFP), .V_SYNC(VS), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble),
        .freeze(freeze), .chan_en(chan_en),
`ifdef VNG_PATTERN_EN
        .pattern(1'b0),
`endif
        .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
        .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
        .video(video)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] seed_of(input int i);
        logic [15:0] s;
        s = 16'hACE1 ^ 16'(i * 16'h1357);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Reference model: raster position of the pixel about to be emitted,
    // latched mode, per-channel noise generators and a buffer holding the
    // last even line so a scandoubled odd line can be compared against it.
    int          mh, mv, gap, line_idx, vact;
    bit          mpal, msd, pend, act, odd;
    logic [15:0] ref_s [CH];
    logic [7:0]  linebuf [CH][HA];
    logic [7:0]  px;
    int          e_h, e_v;
    bit          e_hb, e_hs, e_vb, e_vs;
    logic [CH*CW-1:0] e_vid;

    always @(negedge clk) begin
        if (!reset_n) begin
            mh = 0; mv = 0; mpal = 0; msd = 0; pend = 0; gap = 0;
            for (int i = 0; i < CH; i++) ref_s[i] = seed_of(i);
        end else begin
            if (pend) begin
                chk("hcount", hcount, e_h);
                chk("vcount", vcount, e_v);
                chk("hblank", HBlank, e_hb);
                chk("hsync", HSync, e_hs);
                chk("vblank", VBlank, e_vb);
                chk("vsync", VSync, e_vs);
                chk("video", video, e_vid);
                pend = 0;
            end
            gap++;
            if (ce_pix) begin
                chk("ce_period", gap, msd ? CE / 2 : CE);
                gap = 0;
                line_idx = msd ? mv / 2 : mv;
                vact = mpal ? VAP : VAN;
                e_h = mh;
                e_v = mv;
                e_hb = mh >= HA;
                e_hs = mh >= HA + HFP && mh < HA + HFP + HS;
                e_vb = line_idx >= vact;
                e_vs = line_idx >= vact + VFP && line_idx < vact + VFP + VS;
                act = !e_hb && !e_vb;
                odd = msd && (mv % 2 == 1);
                e_vid = '0;
                if (act) begin
                    for (int i = 0; i < CH; i++) begin
                        px = odd ? linebuf[i][mh] : ref_s[i][15:8];
                        if (!odd) linebuf[i][mh] = px;
                        if (chan_en[i]) e_vid[i*CW +: CW] = px;
                        if (!freeze && !odd) ref_s[i] = galois(ref_s[i]);
                    end
                end
                pend = 1;
                mh++;
                if (mh == HT) begin
                    mh = 0;
                    mv++;
                    if (mv == (mpal ? VTP : VTN) * (msd ? 2 : 1)) begin
                        mv = 0;
                        mpal = pal;
                        msd = scandouble;
                    end
                end
            end
        end
    end

    task automatic first_pixel();
        int n = 0;
        bit seen = 0;
        while (!seen && n < 4 * CE) begin
            @(negedge clk);
            n++;
            seen = ce_pix;
        end
        chk("first_ce_clk", n, CE);
        @(negedge clk);
        chk("first_px_ch0", video[7:0], 8'hAC);
        chk("first_px_ch1", video[15:8], 8'hBF);
        chk("first_px_ch2", video[23:16], 8'h8A);
    endtask

    task automatic wait_out(input int h, input int v);
        bit ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (int'(hcount) == h && int'(vcount) == v) ok = 1;
        end
        chk("wait_timeout", ok, 1);
    endtask

    // Runs until the outputs return to (0,0); reports line count and the
    // vcount/hcount extents over which VSync/HSync were seen.
    task automatic run_frame(output int lines, output int vs_lo, output int vs_hi,
                             output int hs_lo, output int hs_hi);
        int  vmax = 0;
        bit  left = 0;
        bit  done = 0;
        vs_lo = 9999; vs_hi = -1; hs_lo = 9999; hs_hi = -1;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(posedge clk);
            #1;
            if (int'(vcount) > vmax) vmax = int'(vcount);
            if (VSync) begin
                if (int'(vcount) < vs_lo) vs_lo = int'(vcount);
                if (int'(vcount) > vs_hi) vs_hi = int'(vcount);
            end
            if (HSync) begin
                if (int'(hcount) < hs_lo) hs_lo = int'(hcount);
                if (int'(hcount) > hs_hi) hs_hi = int'(hcount);
            end
            if (hcount != 0 || vcount != 0) left = 1;
            else if (left) done = 1;
        end
        chk("frame_timeout", done, 1);
        lines = vmax + 1;
    endtask

    initial begin
        int lines, vlo, vhi, hlo, hhi;
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_video", video, 0);
        chk("rst_hcount", hcount, 0);
        chk("rst_vcount", vcount, 0);
        chk("rst_timing", {HBlank, HSync, VBlank, VSync}, 0);
        chk("rst_ce", ce_pix, 0);
        reset_n = 1;
        first_pixel();

        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("ntsc_lines", lines, VTN);
        chk("ntsc_vs_lo", vlo, VAN + VFP);
        chk("ntsc_vs_hi", vhi, VAN + VFP + VS - 1);
        chk("hs_lo", hlo, HA + HFP);
        chk("hs_hi", hhi, HA + HFP + HS - 1);

        wait_out(0, 4);
        pal = 1;
        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("pal_midframe_lines", lines, VTN);
        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("pal_lines", lines, VTP);
        chk("pal_vs_lo", vlo, VAP + VFP);
        chk("pal_vs_hi", vhi, VAP + VFP + VS - 1);

        wait_out(0, 5);
        scandouble = 1;
        chan_en = 3'($urandom);
        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("sd_midframe_lines", lines, VTP);
        chan_en = 3'($urandom);
        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("sd_lines", lines, 2 * VTP);
        chk("sd_vs_lo", vlo, 2 * (VAP + VFP));
        chk("sd_vs_hi", vhi, 2 * (VAP + VFP + VS) - 1);
        pal = 0;
        scandouble = 0;
        chan_en = 3'b111;
        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("sd_tail_lines", lines, 2 * VTP);
        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("ntsc_again_lines", lines, VTN);

        freeze = 1;
        run_frame(lines, vlo, vhi, hlo, hhi);
        run_frame(lines, vlo, vhi, hlo, hhi);
        freeze = 0;
        run_frame(lines, vlo, vhi, hlo, hhi);

        chan_en = 3'b010;
        run_frame(lines, vlo, vhi, hlo, hhi);

        for (int f = 0; f < 3; f++) begin
            pal = 1'($urandom);
            chan_en = 3'($urandom);
            repeat ($urandom_range(50, 600)) @(posedge clk);
            #1;
            freeze = 1'($urandom);
            run_frame(lines, vlo, vhi, hlo, hhi);
        end
        freeze = 0;
        pal = 0;
        chan_en = 3'b111;
        run_frame(lines, vlo, vhi, hlo, hhi);

        wait_out(10, 3);
        repeat ($urandom_range(0, CE - 1)) @(posedge clk);
        #1;
        reset_n = 0;
        #1;
        chk("midrst_video", video, 0);
        chk("midrst_hcount", hcount, 0);
        chk("midrst_vcount", vcount, 0);
        chk("midrst_timing", {HBlank, HSync, VBlank, VSync}, 0);
        chk("midrst_ce", ce_pix, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        first_pixel();
        run_frame(lines, vlo, vhi, hlo, hhi);
        chk("post_rst_lines", lines, VTN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
